// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ==========================================================================
// data_mem_arbiter_pkg: shared encodings for the data RAM arbiter. Rev 1.0
// ==========================================================================
package data_mem_arbiter_pkg;

  localparam logic [0:0] S_CORE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Indexed by size code: bytes touched by an access starting at lane 0.
  localparam logic [3:0][7:0] BYTE_MASK = {8'hFF, 8'h0F, 8'h03, 8'h01};

  function automatic logic [2:0] align_bits(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_load_formatter.sv
`default_nettype none
// ==========================================================================
// load_formatter: lane extraction plus sign/zero extension of load data. Rev 1.0
// ==========================================================================
module load_formatter
  import data_mem_arbiter_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [63:0] data_o
);

  logic [63:0] w_sh;

  assign w_sh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = w_sh;
    case (size_i)
      SZ_B:    data_o = uns_i ? {56'd0, w_sh[7:0]}  : {{56{w_sh[7]}},  w_sh[7:0]};
      SZ_H:    data_o = uns_i ? {48'd0, w_sh[15:0]} : {{48{w_sh[15]}}, w_sh[15:0]};
      SZ_W:    data_o = uns_i ? {32'd0, w_sh[31:0]} : {{32{w_sh[31]}}, w_sh[31:0]};
      default: data_o = w_sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// data_mem_arbiter: shares the data RAM between MEM stage and loader. Rev 1.0
// ==========================================================================
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              cReq,
  input  logic              cWe,
  input  logic [ADDR_W-1:0] cAddr,
  input  logic [63:0]       cWdata,
  input  logic [2:0]        cFunct3,
  output logic              cStall,
  output logic              cMisalign,
  output logic [63:0]       cRdata,
  output logic              cRvalid,
  input  logic              lReq,
  input  logic              lLock,
  input  logic              lWe,
  input  logic [ADDR_W-1:0] lAddr,
  input  logic [63:0]       lWdata,
  output logic              lGnt,
  output logic [63:0]       lRdata,
  output logic              lRvalid,
  output logic              ramEn,
  output logic [7:0]        ramBe,
  output logic [ADDR_W-4:0] ramAddr,
  output logic [63:0]       ramWdata,
  input  logic [63:0]       ramRdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BURST_LIM  = BW'(MAX_BURST);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          core_pri_q, core_pri_d;
  logic          c_rd_q, c_rd_d;
  logic          l_rd_q, l_rd_d;
  logic [2:0]    off_q;
  logic [1:0]    size_q;
  logic          uns_q;

  logic [2:0]    w_off;
  logic [1:0]    w_size;
  logic          w_misal, w_c_ok, w_l_gnt, w_c_gnt, w_unused;
  logic [BW-1:0] w_burst_inc;
  logic [63:0]   w_fmt;

  assign w_off       = cAddr[2:0];
  assign w_size      = cFunct3[1:0];
  assign w_misal     = |(w_off & align_bits(w_size));
  assign cMisalign   = cReq && w_misal;
  assign w_c_ok      = cReq && !w_misal;
  assign w_burst_inc = burst_q + BW'(1);
  assign w_unused    = ^lAddr[2:0];

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q    <= S_CORE;
      starve_q   <= '0;
      burst_q    <= '0;
      core_pri_q <= 1'b0;
      c_rd_q     <= 1'b0;
      l_rd_q     <= 1'b0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      burst_q    <= burst_d;
      core_pri_q <= core_pri_d;
      c_rd_q     <= c_rd_d;
      l_rd_q     <= l_rd_d;
      if (w_c_gnt) begin
        off_q  <= w_off;
        size_q <= w_size;
        uns_q  <= cFunct3[2];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = '0;
    burst_d    = burst_q;
    core_pri_d = 1'b0;
    c_rd_d     = w_c_gnt && !cWe;
    l_rd_d     = w_l_gnt && !lWe;
    case (state_q)
      S_CORE: begin
        burst_d = '0;
        if (!w_l_gnt && lReq)
          starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
        if (w_l_gnt && lLock) begin
          state_d = S_LOCK;
          burst_d = BW'(1);
        end
      end
      default: begin
        if (lReq) burst_d = w_burst_inc;
        // A burst that hits its beat limit hands the core one guaranteed cycle.
        if (lReq && (w_burst_inc == BURST_LIM)) begin
          state_d    = S_CORE;
          burst_d    = '0;
          core_pri_d = 1'b1;
        end else if (!lLock) begin
          state_d = S_CORE;
          burst_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    w_l_gnt  = 1'b0;
    w_c_gnt  = 1'b0;
    ramEn    = 1'b0;
    ramBe    = 8'h00;
    ramAddr  = '0;
    ramWdata = '0;
    if (state_q == S_LOCK) begin
      w_l_gnt = lReq;
    end else begin
      w_l_gnt = lReq && (cMisalign || !cReq || (!core_pri_q && (starve_q == STARVE_LIM)));
      w_c_gnt = w_c_ok && !w_l_gnt;
    end
    if (w_l_gnt) begin
      ramEn    = 1'b1;
      ramBe    = lWe ? 8'hFF : 8'h00;
      ramAddr  = lAddr[ADDR_W-1:3];
      ramWdata = lWdata;
    end else if (w_c_gnt) begin
      ramEn    = 1'b1;
      ramBe    = cWe ? (BYTE_MASK[w_size] << w_off) : 8'h00;
      ramAddr  = cAddr[ADDR_W-1:3];
      ramWdata = cWdata << {w_off, 3'b000};
    end
  end

  assign cStall  = w_c_ok && !w_c_gnt;
  assign lGnt    = w_l_gnt;
  assign cRvalid = c_rd_q;
  assign lRvalid = l_rd_q;
  assign cRdata  = c_rd_q ? w_fmt : 64'd0;
  assign lRdata  = l_rd_q ? ramRdata : 64'd0;

  load_formatter u_load_formatter (
    .rdata_i (ramRdata),
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .data_o  (w_fmt)
  );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_data_mem_arbiter: directed and randomized checks of the data RAM arbiter. Rev 1.0
// ==========================================================================
module tb_data_mem_arbiter;

  localparam int ADDR_W     = 16;
  localparam int STARVE_MAX = 4;
  localparam int MAX_BURST  = 8;

  logic              clk = 1'b0;
  logic              rstN;
  logic              cReq, cWe, cStall, cMisalign, cRvalid;
  logic [ADDR_W-1:0] cAddr;
  logic [63:0]       cWdata, cRdata;
  logic [2:0]        cFunct3;
  logic              lReq, lLock, lWe, lGnt, lRvalid;
  logic [ADDR_W-1:0] lAddr;
  logic [63:0]       lWdata, lRdata;
  logic              ramEn;
  logic [7:0]        ramBe;
  logic [ADDR_W-4:0] ramAddr;
  logic [63:0]       ramWdata, ramRdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] ram     [0:8191];
  logic [7:0]  ref_mem [0:65535];

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .cReq      (cReq),
    .cWe       (cWe),
    .cAddr     (cAddr),
    .cWdata    (cWdata),
    .cFunct3   (cFunct3),
    .cStall    (cStall),
    .cMisalign (cMisalign),
    .cRdata    (cRdata),
    .cRvalid   (cRvalid),
    .lReq      (lReq),
    .lLock     (lLock),
    .lWe       (lWe),
    .lAddr     (lAddr),
    .lWdata    (lWdata),
    .lGnt      (lGnt),
    .lRdata    (lRdata),
    .lRvalid   (lRvalid),
    .ramEn     (ramEn),
    .ramBe     (ramBe),
    .ramAddr   (ramAddr),
    .ramWdata  (ramWdata),
    .ramRdata  (ramRdata)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ramEn) begin
      ramRdata <= ram[ramAddr];
      for (int i = 0; i < 8; i++)
        if (ramBe[i]) ram[ramAddr][8*i +: 8] <= ramWdata[8*i +: 8];
    end
  end

  task automatic drive_core(input logic req, input logic we, input logic [2:0] f3,
                            input logic [15:0] a, input logic [63:0] d);
    cReq = req; cWe = we; cFunct3 = f3; cAddr = a; cWdata = d;
  endtask

  task automatic drive_ldr(input logic req, input logic lock, input logic we,
                           input logic [15:0] a, input logic [63:0] d);
    lReq = req; lLock = lock; lWe = we; lAddr = a; lWdata = d;
  endtask

  function automatic logic [63:0] ref_load(input logic [15:0] a, input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
    if (f3[1:0] != 2'd3 && !f3[2] && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rstN = 1'b0;
    drive_core(0, 0, 0, 0, 0);
    drive_ldr(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++; if (cRvalid !== 1'b0) begin n_fail++; $display("FAIL reset_crvalid got %b expected 0", cRvalid); end
    n_tests++; if (lRvalid !== 1'b0) begin n_fail++; $display("FAIL reset_lrvalid got %b expected 0", lRvalid); end
    n_tests++; if (cRdata !== 64'd0) begin n_fail++; $display("FAIL reset_crdata got %h expected 0", cRdata); end
    n_tests++; if (lRdata !== 64'd0) begin n_fail++; $display("FAIL reset_lrdata got %h expected 0", lRdata); end
    n_tests++; if ({ramEn, ramBe} !== 9'h000) begin n_fail++; $display("FAIL reset_ram_idle got %h expected 000", {ramEn, ramBe}); end
    rstN = 1'b1;
  endtask

  task automatic test_store_load();
    @(negedge clk);
    drive_core(1, 1, 3'd3, 16'h0010, 64'h1122334455667788);
    #1;
    n_tests++; if ({ramEn, ramBe} !== 9'h1FF) begin n_fail++; $display("FAIL sd_lanes got %h expected 1ff", {ramEn, ramBe}); end
    n_tests++; if (ramAddr !== 13'h0002) begin n_fail++; $display("FAIL sd_addr got %h expected 0002", ramAddr); end
    @(negedge clk);
    n_tests++; if (cRvalid !== 1'b0) begin n_fail++; $display("FAIL sd_no_rvalid got %b expected 0", cRvalid); end
    drive_core(1, 0, 3'd0, 16'h0017, 64'd0);
    #1;
    n_tests++; if ({ramEn, ramBe, cStall} !== 10'h200) begin n_fail++; $display("FAIL lb_port got %h expected 200", {ramEn, ramBe, cStall}); end
    @(negedge clk);
    n_tests++; if ({cRvalid, cRdata} !== {1'b1, 64'h11}) begin n_fail++; $display("FAIL lb_0x17 got %b/%h expected 1/0000000000000011", cRvalid, cRdata); end
    drive_core(1, 1, 3'd0, 16'h0013, 64'h80);
    #1;
    n_tests++; if (ramBe !== 8'h08) begin n_fail++; $display("FAIL sb_be got %h expected 08", ramBe); end
    n_tests++; if (ramWdata !== 64'h0000000080000000) begin n_fail++; $display("FAIL sb_wdata got %h expected 0000000080000000", ramWdata); end
    @(negedge clk);
    drive_core(1, 0, 3'd0, 16'h0013, 64'd0);
    @(negedge clk);
    n_tests++; if ({cRvalid, cRdata} !== {1'b1, 64'hFFFFFFFFFFFFFF80}) begin n_fail++; $display("FAIL lb_sext got %b/%h expected 1/ffffffffffffff80", cRvalid, cRdata); end
    drive_core(1, 0, 3'd4, 16'h0013, 64'd0);
    @(negedge clk);
    n_tests++; if ({cRvalid, cRdata} !== {1'b1, 64'h80}) begin n_fail++; $display("FAIL lbu_zext got %b/%h expected 1/0000000000000080", cRvalid, cRdata); end
    drive_core(1, 0, 3'd1, 16'h0016, 64'd0);
    @(negedge clk);
    n_tests++; if ({cRvalid, cRdata} !== {1'b1, 64'h1122}) begin n_fail++; $display("FAIL lh_0x16 got %b/%h expected 1/0000000000001122", cRvalid, cRdata); end
    drive_core(1, 0, 3'd2, 16'h0010, 64'd0);
    @(negedge clk);
    n_tests++; if ({cRvalid, cRdata} !== {1'b1, 64'hFFFFFFFF80667788}) begin n_fail++; $display("FAIL lw_sext got %b/%h expected 1/ffffffff80667788", cRvalid, cRdata); end
    drive_core(0, 0, 0, 0, 0);
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drive_core(1, 0, 3'd2, 16'h0006, 64'd0);
    #1;
    n_tests++; if ({cMisalign, ramEn, cStall} !== 3'b100) begin n_fail++; $display("FAIL misalign_flags got %b expected 100", {cMisalign, ramEn, cStall}); end
    @(negedge clk);
    n_tests++; if (cRvalid !== 1'b0) begin n_fail++; $display("FAIL misalign_no_rvalid got %b expected 0", cRvalid); end
    drive_ldr(1, 0, 0, 16'h0010, 64'd0);
    #1;
    n_tests++; if ({lGnt, cStall} !== 2'b10) begin n_fail++; $display("FAIL misalign_ldr_gnt got %b expected 10", {lGnt, cStall}); end
    @(negedge clk);
    n_tests++; if ({lRvalid, lRdata} !== {1'b1, 64'h1122334480667788}) begin n_fail++; $display("FAIL ldr_read got %b/%h expected 1/1122334480667788", lRvalid, lRdata); end
    drive_core(0, 0, 0, 0, 0);
    drive_ldr(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int gnt_at;
    gnt_at = 0;
    @(negedge clk);
    drive_core(1, 0, 3'd3, 16'h0010, 64'd0);
    drive_ldr(1, 0, 0, 16'h0018, 64'd0);
    for (int k = 1; k <= 8 && gnt_at == 0; k++) begin
      #1;
      if (lGnt) begin
        gnt_at = k;
        n_tests++; if (cStall !== 1'b1) begin n_fail++; $display("FAIL starve_stall got %b expected 1", cStall); end
      end else begin
        n_tests++; if (cStall !== 1'b0) begin n_fail++; $display("FAIL starve_core_gnt cycle %0d got %b expected 0", k, cStall); end
      end
      @(negedge clk);
    end
    n_tests++; if (gnt_at !== 5) begin n_fail++; $display("FAIL starve_cycle got %0d expected 5", gnt_at); end
    drive_core(0, 0, 0, 0, 0);
    drive_ldr(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [15:0] lgv;
    int core_cyc, beats, stalls;
    bit got;
    lgv = '0; core_cyc = -1; beats = 0; stalls = 0;
    @(negedge clk);
    drive_core(0, 0, 0, 0, 0);
    drive_ldr(1, 1, 1, 16'h0040, 64'hB000);
    for (int cyc = 0; cyc < 16 && beats < 10; cyc++) begin
      if (cyc == 1) drive_core(1, 0, 3'd3, 16'h0010, 64'd0);
      #1;
      got = lGnt;
      if (got) begin lgv[cyc] = 1'b1; beats++; end
      if (cReq && cStall) stalls++;
      if (cReq && !cStall && !cMisalign) core_cyc = cyc;
      @(negedge clk);
      if (core_cyc >= 0) drive_core(0, 0, 0, 0, 0);
      if (got) drive_ldr(beats < 10, beats < 10, 1, 16'(16'h0040 + 8*beats), 64'hB000 + 64'(beats));
    end
    n_tests++; if (lgv !== 16'h06FF) begin n_fail++; $display("FAIL burst_gnt_pattern got %h expected 06ff", lgv); end
    n_tests++; if (core_cyc !== 8) begin n_fail++; $display("FAIL burst_core_slot got %0d expected 8", core_cyc); end
    n_tests++; if (stalls !== 7) begin n_fail++; $display("FAIL burst_core_stalls got %0d expected 7", stalls); end
    @(negedge clk);
    drive_core(1, 0, 3'd3, 16'h0048, 64'd0);
    #1;
    n_tests++; if (cStall !== 1'b0) begin n_fail++; $display("FAIL burst_exit_core got %b expected 0", cStall); end
    @(negedge clk);
    n_tests++; if ({cRvalid, cRdata} !== {1'b1, 64'hB001}) begin n_fail++; $display("FAIL burst_data got %b/%h expected 1/000000000000b001", cRvalid, cRdata); end
    drive_core(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_reset_midburst();
    @(negedge clk);
    drive_ldr(1, 1, 0, 16'h0040, 64'd0);
    @(negedge clk);
    drive_ldr(1, 1, 0, 16'h0048, 64'd0);
    @(negedge clk);
    drive_ldr(1, 1, 0, 16'h0050, 64'd0);
    drive_core(1, 0, 3'd3, 16'h0010, 64'd0);
    rstN = 1'b0;
    #1;
    n_tests++; if ({lGnt, cStall} !== 2'b11) begin n_fail++; $display("FAIL rst_beat3 got %b expected 11", {lGnt, cStall}); end
    @(negedge clk);
    rstN = 1'b1;
    n_tests++; if ({lRvalid, lRdata, cRvalid} !== {1'b0, 64'd0, 1'b0}) begin n_fail++; $display("FAIL rst_discard got %b/%h/%b expected 0/0/0", lRvalid, lRdata, cRvalid); end
    #1;
    n_tests++; if ({lGnt, cStall} !== 2'b00) begin n_fail++; $display("FAIL rst_core_gnt got %b expected 00", {lGnt, cStall}); end
    @(negedge clk);
    n_tests++; if ({cRvalid, cRdata} !== {1'b1, 64'h1122334480667788}) begin n_fail++; $display("FAIL rst_core_data got %b/%h expected 1/1122334480667788", cRvalid, cRdata); end
    drive_core(0, 0, 0, 0, 0);
    drive_ldr(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Reference: byte-addressed memory plus the arbitration rules in integer form.
  task automatic test_random();
    int m_wait, m_beats, burst_left, sz;
    bit m_locked, m_cf, exp_cv, exp_lv, c_hold, l_hold, lg, cg, mis, limit;
    logic [63:0] exp_cd, exp_ld;
    m_wait = 0; m_beats = 0; burst_left = 0; m_locked = 0; m_cf = 0;
    exp_cv = 0; exp_lv = 0; c_hold = 0; l_hold = 0; exp_cd = '0; exp_ld = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      n_tests++; if (cRvalid !== exp_cv || (exp_cv && cRdata !== exp_cd)) begin n_fail++; $display("FAIL rnd_cload cyc %0d got %b/%h expected %b/%h", cyc, cRvalid, cRdata, exp_cv, exp_cd); end
      n_tests++; if (lRvalid !== exp_lv || (exp_lv && lRdata !== exp_ld)) begin n_fail++; $display("FAIL rnd_lload cyc %0d got %b/%h expected %b/%h", cyc, lRvalid, lRdata, exp_lv, exp_ld); end
      if (!c_hold) begin
        if ($urandom_range(0, 9) < 6)
          drive_core(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     16'h0200 + 16'($urandom_range(0, 255)), {$urandom, $urandom});
        else
          drive_core(0, 0, 0, 0, 0);
      end
      if (!l_hold) begin
        if (burst_left == 0 && $urandom_range(0, 5) == 0) burst_left = $urandom_range(2, 12);
        if (burst_left > 0) begin
          drive_ldr(1, burst_left > 1, 1'($urandom_range(0, 1)),
                    16'h0200 + 16'(8 * $urandom_range(0, 31)), {$urandom, $urandom});
          burst_left--;
        end else begin
          drive_ldr($urandom_range(0, 2) == 0, 0, 1'($urandom_range(0, 1)),
                    16'h0200 + 16'(8 * $urandom_range(0, 31)), {$urandom, $urandom});
        end
      end
      #1;
      sz  = int'(cFunct3[1:0]);
      mis = cReq && ((int'(cAddr) % (1 << sz)) != 0);
      if (m_locked) begin
        lg = lReq;
        cg = 0;
      end else begin
        lg = lReq && (mis || !cReq || (m_wait >= STARVE_MAX && !m_cf));
        cg = cReq && !mis && !lg;
      end
      n_tests++; if (lGnt !== lg) begin n_fail++; $display("FAIL rnd_lgnt cyc %0d got %b expected %b", cyc, lGnt, lg); end
      n_tests++; if (cStall !== (cReq && !mis && !cg)) begin n_fail++; $display("FAIL rnd_cstall cyc %0d got %b expected %b", cyc, cStall, cReq && !mis && !cg); end
      n_tests++; if (cMisalign !== mis) begin n_fail++; $display("FAIL rnd_misalign cyc %0d got %b expected %b", cyc, cMisalign, mis); end
      if (!lg && !cg) begin
        n_tests++; if ({ramEn, ramBe} !== 9'h000) begin n_fail++; $display("FAIL rnd_ram_idle cyc %0d got %h expected 000", cyc, {ramEn, ramBe}); end
      end
      exp_cv = 0;
      exp_lv = 0;
      if (cg) begin
        if (cWe) for (int i = 0; i < (1 << sz); i++) ref_mem[int'(cAddr) + i] = cWdata[8*i +: 8];
        else begin exp_cv = 1; exp_cd = ref_load(cAddr, cFunct3); end
      end
      if (lg) begin
        if (lWe) for (int i = 0; i < 8; i++) ref_mem[int'(lAddr) + i] = lWdata[8*i +: 8];
        else begin exp_lv = 1; exp_ld = ref_load(lAddr, 3'd3); end
      end
      c_hold = cReq && !mis && !cg;
      l_hold = lReq && !lg;
      if (m_locked) begin
        if (lg) m_beats++;
        limit = lg && (m_beats == MAX_BURST);
        if (!lLock || limit) m_locked = 0;
        m_cf   = limit;
        m_wait = 0;
      end else begin
        m_cf = 0;
        if (lg) begin
          m_wait = 0;
          if (lLock) begin m_locked = 1; m_beats = 1; end
        end else if (lReq) begin
          m_wait = (m_wait + 1 > STARVE_MAX) ? STARVE_MAX : m_wait + 1;
        end else begin
          m_wait = 0;
        end
      end
    end
    @(negedge clk);
    n_tests++; if (cRvalid !== exp_cv || (exp_cv && cRdata !== exp_cd)) begin n_fail++; $display("FAIL rnd_cload_last got %b/%h expected %b/%h", cRvalid, cRdata, exp_cv, exp_cd); end
    drive_core(0, 0, 0, 0, 0);
    drive_ldr(0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
    ramRdata = '0;
    rstN = 1'b0;
    drive_core(0, 0, 0, 0, 0);
    drive_ldr(0, 0, 0, 0, 0);
    test_reset();
    test_store_load();
    test_misalign();
    test_starvation();
    test_burst();
    test_reset_midburst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
